mult_pipe: RTL
==============

# mult_pipe

Parametrised pipelined integer multiplier for the execute-stage multiply path. Accepts one operation per cycle with signed/unsigned and low/high-half selection. Stage 0 registers the operands together with the zero and result-sign flags; the product is formed on magnitudes and re-signed at the last stage. Adds stall and flush control so the multiply lane can be frozen or squashed by the pipeline controller.

## Interface

Parameters:
- WIDTH, 32, operand and result width (≥ 4)
- STAGES, 3, pipeline depth and latency in cycles (≥ 2)
- DEST_W, 5, destination register index width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears every register immediately
- in_oper  in  1  operation valid this cycle
- in_rega  in  WIDTH  multiplicand
- in_regb  in  WIDTH  multiplier
- in_regdest  in  DEST_W  destination register tag
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_high  in  1  1 = return product bits [2·WIDTH-1:WIDTH], 0 = bits [WIDTH-1:0]
- stall  in  1  freeze the whole pipeline
- flush  in  1  squash every in-flight operation
- out_oper  out  1  result valid
- out_result  out  WIDTH  selected product half
- out_regdest  out  DEST_W  tag of the result
- inflight  out  $clog2(STAGES+1)  number of valid operations currently in the pipeline

## Operation

- **Stage 0** captures operands, tag, mode bits and flags:
  - iszero = (rega == 0) || (regb == 0).
  - Negative flag per operand = in_signed && MSB.
  - Result negative = neg_a XOR neg_b, forced 0 when iszero.
  - Magnitudes are |x| as unsigned WIDTH-bit values; -2^(WIDTH-1) maps to 2^(WIDTH-1), with no overflow.
- **Stage 1** forms the 2·WIDTH-bit unsigned product of the magnitudes.
  - Stages 2..STAGES-2 carry the product and control unchanged.
- **Final stage**:
  - Negates the product in 2·WIDTH bits if the result is negative.
  - Selects the half given by in_high.
  - Forces the result to 0 if iszero.
  - Registers the result to the outputs.
- **Invalid slots:** when a slot is not valid, its payload registers (operands, product, tag, flags, result) load 0, so out_result = 0 and out_regdest = 0 whenever out_oper = 0.
- **stall = 1:** every stage register, including the outputs and inflight, holds its value. in_oper is ignored and dropped; the issuing stage must not present an operation during a stall.
- **flush = 1:** all valid bits and payloads clear to 0 on the next edge, and inflight goes to 0. flush has priority over stall and over a simultaneous in_oper, so an operation entering that cycle is discarded.
- **inflight:** counts valid bits across all STAGES registers.
  - Increments on accept and decrements as an operation leaves the final register.
  - Accept and retire in the same cycle leave it unchanged.
  - It never exceeds STAGES.

## Timing

- **Reset values:** every output is 0 (out_oper, out_result, out_regdest, inflight) and every internal register is 0. Reset asserted mid-operation discards all in-flight operations with no partial output.
- **Latency:** an operation accepted at edge N appears with out_oper = 1 after edge N+STAGES-1, i.e. exactly STAGES register stages with no stall. Each stall cycle adds one cycle.
- **Throughput:** one operation per cycle; back-to-back inputs produce back-to-back outputs in order.
- **Output pulse:** out_oper is high for one cycle per operation, or longer while stalled with the result held.
- **No combinational paths:** no output depends combinationally on any input.

## Structure

- **Shared package** (multiply-lane definitions shared with the decode and writeback stages):
  - mult_mode_t {signed, high} struct.
  - MULT_STAGES_DEFAULT constant.
  - Stage-control struct {oper, regdest, mode, neg, iszero}.
- **Sub-module** mult_pipe_front: stage 0, the flag and magnitude capture. It is the only natural split; the remaining stages are a generate loop over a payload shift chain.

## Test plan

- **Signed low half:** WIDTH=32, STAGES=3, signed, low, -3 × 5 (0xFFFFFFFD, 0x00000005), tag 7 -> out_result 0xFFFFFFF1 and out_regdest 7 exactly 3 cycles after accept.
- **Corner operands:**
  - Signed high, 0x80000000 × 0x80000000 -> 0x40000000.
  - Signed low, same operands -> 0x00000000.
  - Unsigned high, 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - Unsigned low, same operands -> 0x00000001.
- **Zero operand:** signed high, 0 × 0xFFFFFFFF -> 0x00000000. Signed high, -1 × 1 -> 0xFFFFFFFF.
- **Stream with stall:** five back-to-back operations with tags 1..5, stall held 2 cycles mid-stream -> all five emerge in order, with outputs frozen during the stall, total latency 3+2 for the affected ops, and inflight peaking at 3.
- **Flush:** flush asserted with 3 ops in flight plus in_oper = 1 -> out_oper = 0 and inflight = 0 next cycle; no results ever appear.
- **Reset mid-operation:** reset pulsed asynchronously mid-stream -> all outputs 0 immediately. The first operation after release has normal latency.
- **Random regression:** STAGES = 2 and 5 against a 64-bit reference model.

Source files
------------

// File: rtl/mult_pipe_pkg.sv
// Multiply-lane definitions shared by decode, execute and writeback.
// Mode bits, default depth and the per-stage control bundle.
package mult_pipe_pkg;

   localparam int MULT_STAGES_DEFAULT = 3;

   // Tag field is sized for the widest register file; narrower
   // instances zero-extend into it.
   localparam int MULT_DEST_MAX = 8;

   typedef struct packed {
      logic sgn;
      logic high;
   } mult_mode_t;

   typedef struct packed {
      logic                     oper;
      logic [MULT_DEST_MAX-1:0] regdest;
      mult_mode_t               mode;
      logic                     neg;
      logic                     iszero;
   } mult_ctrl_t;

endpackage

// File: rtl/mult_pipe_front.sv
// Stage 0 of the multiplier: operand capture, magnitudes and flags.
// Ports: operands/tag/mode in, stall/flush; ctrl bundle and magnitudes out.
module mult_pipe_front
   import mult_pipe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEST_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_oper,
   input  logic [WIDTH-1:0]  in_rega,
   input  logic [WIDTH-1:0]  in_regb,
   input  logic [DEST_W-1:0] in_regdest,
   input  logic              in_signed,
   input  logic              in_high,
   input  logic              stall,
   input  logic              flush,
   output mult_ctrl_t        ctrl,
   output logic [WIDTH-1:0]  mag_a,
   output logic [WIDTH-1:0]  mag_b
);

   logic       neg_a;
   logic       neg_b;
   logic       iszero;
   mult_ctrl_t nxt;
   logic [WIDTH-1:0] nxt_a;
   logic [WIDTH-1:0] nxt_b;

   always_comb begin
      neg_a  = in_signed & in_rega[WIDTH-1];
      neg_b  = in_signed & in_regb[WIDTH-1];
      iszero = (in_rega == '0) || (in_regb == '0);
      nxt    = '0;
      nxt_a  = '0;
      nxt_b  = '0;
      // Invalid slots carry an all-zero payload down the chain.
      if (in_oper) begin
         nxt.oper                = 1'b1;
         nxt.regdest[DEST_W-1:0] = in_regdest;
         nxt.mode.sgn            = in_signed;
         nxt.mode.high           = in_high;
         nxt.neg                 = (neg_a ^ neg_b) & ~iszero;
         nxt.iszero              = iszero;
         // Most-negative value negates to itself, which is the
         // correct unsigned magnitude 2^(WIDTH-1).
         nxt_a = neg_a ? -in_rega : in_rega;
         nxt_b = neg_b ? -in_regb : in_regb;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ctrl  <= '0;
         mag_a <= '0;
         mag_b <= '0;
      end else if (flush) begin
         ctrl  <= '0;
         mag_a <= '0;
         mag_b <= '0;
      end else if (!stall) begin
         ctrl  <= nxt;
         mag_a <= nxt_a;
         mag_b <= nxt_b;
      end
   end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined signed/unsigned multiplier with stall and flush.
// Ports: clock/reset, op inputs, stall/flush; result, tag, valid, inflight.
module mult_pipe
   import mult_pipe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = MULT_STAGES_DEFAULT,
   parameter int DEST_W = 5
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        in_oper,
   input  logic [WIDTH-1:0]            in_rega,
   input  logic [WIDTH-1:0]            in_regb,
   input  logic [DEST_W-1:0]           in_regdest,
   input  logic                        in_signed,
   input  logic                        in_high,
   input  logic                        stall,
   input  logic                        flush,
   output logic                        out_oper,
   output logic [WIDTH-1:0]            out_result,
   output logic [DEST_W-1:0]           out_regdest,
   output logic [$clog2(STAGES+1)-1:0] inflight
);

   localparam int P  = 2 * WIDTH;
   localparam int IW = $clog2(STAGES+1);

   mult_ctrl_t       f_ctrl;
   logic [WIDTH-1:0] f_a;
   logic [WIDTH-1:0] f_b;
   logic [P-1:0]     f_prod;
   logic [P-1:0]     mid_prod;
   mult_ctrl_t       mid_ctrl;
   logic [P-1:0]     sgn_prod;
   logic [WIDTH-1:0] half;
   logic [WIDTH-1:0] res_d;
   logic             unused_bits;

   mult_pipe_front #(
      .WIDTH  (WIDTH),
      .DEST_W (DEST_W)
   ) u_front (
      .clock      (clock),
      .reset      (reset),
      .in_oper    (in_oper),
      .in_rega    (in_rega),
      .in_regb    (in_regb),
      .in_regdest (in_regdest),
      .in_signed  (in_signed),
      .in_high    (in_high),
      .stall      (stall),
      .flush      (flush),
      .ctrl       (f_ctrl),
      .mag_a      (f_a),
      .mag_b      (f_b)
   );

   assign f_prod = P'(f_a) * P'(f_b);

   generate
      if (STAGES == 2) begin : g_short
         // Two-deep pipe: product and re-sign share the last stage.
         assign mid_prod = f_prod;
         assign mid_ctrl = f_ctrl;
      end else begin : g_chain
         logic [P-1:0] prod_q [1:STAGES-2];
         mult_ctrl_t   ctrl_q [1:STAGES-2];

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               for (int k = 1; k <= STAGES-2; k++) begin
                  prod_q[k] <= '0;
                  ctrl_q[k] <= '0;
               end
            end else if (flush) begin
               for (int k = 1; k <= STAGES-2; k++) begin
                  prod_q[k] <= '0;
                  ctrl_q[k] <= '0;
               end
            end else if (!stall) begin
               prod_q[1] <= f_prod;
               ctrl_q[1] <= f_ctrl;
               for (int k = 2; k <= STAGES-2; k++) begin
                  prod_q[k] <= prod_q[k-1];
                  ctrl_q[k] <= ctrl_q[k-1];
               end
            end
         end

         assign mid_prod = prod_q[STAGES-2];
         assign mid_ctrl = ctrl_q[STAGES-2];
      end
   endgenerate

   always_comb begin
      sgn_prod = mid_ctrl.neg ? -mid_prod : mid_prod;
      half     = mid_ctrl.mode.high ? sgn_prod[P-1:WIDTH]
                                    : sgn_prod[WIDTH-1:0];
      res_d    = '0;
      if (mid_ctrl.oper && !mid_ctrl.iszero)
         res_d = half;
   end

   // Mode sign and the tag padding are consumed in stage 0 only.
   assign unused_bits = ^{mid_ctrl.mode.sgn, mid_ctrl.regdest};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_oper    <= 1'b0;
         out_result  <= '0;
         out_regdest <= '0;
         inflight    <= '0;
      end else if (flush) begin
         out_oper    <= 1'b0;
         out_result  <= '0;
         out_regdest <= '0;
         inflight    <= '0;
      end else if (!stall) begin
         out_oper    <= mid_ctrl.oper;
         out_result  <= res_d;
         out_regdest <= mid_ctrl.regdest[DEST_W-1:0];
         // The op in the output register leaves on this edge.
         inflight    <= inflight + IW'(in_oper) - IW'(out_oper);
      end
   end

endmodule
